microcode_sequencer: RTL and testbench
======================================

# microcode_sequencer

Control sequencer for the 8-bit SAP-1.5 CPU. It steps each instruction through fetch and execute micro-steps and drives every datapath control line, including the program counter's increment (`pc_enable`) and jump-load (`pc_load`) strobes. It sits between the instruction register and flag registers on one side and the bus-attached datapath (PC, MAR, RAM, IR, A, B, ALU, output register) on the other.

## Interface
- No parameters. The instruction format is fixed: 4-bit opcode in the upper nibble of the IR, 4-bit operand in the lower nibble.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 4: upper nibble of the IR, valid from the first EXEC1 cycle onward.
- `flag_carry` in 1: registered carry flag.
- `flag_zero` in 1: registered zero flag.
- `pc_oe` out 1: PC drives the bus.
- `pc_enable` out 1: PC increments at the clock edge.
- `pc_load` out 1: PC loads from the bus.
- `mar_load` out 1: MAR loads from the bus.
- `ram_oe` out 1: RAM drives the bus.
- `ram_we` out 1: RAM writes the bus value at the MAR address.
- `ir_load` out 1: IR loads from the bus.
- `ir_oe` out 1: IR operand nibble drives the bus, zero-extended.
- `a_load` out 1: A register loads from the bus.
- `a_oe` out 1: A register drives the bus.
- `b_load` out 1: B register loads from the bus.
- `alu_oe` out 1: ALU result drives the bus.
- `alu_sub` out 1: ALU subtracts (A−B); otherwise it adds.
- `flags_load` out 1: carry and zero flags update.
- `out_load` out 1: output register loads from the bus.
- `halt` out 1: CPU halted.
- `t_state` out 3: current step, for debug. Encoding: FETCH_ADDR=0, FETCH_INSTR=1, EXEC1=2, EXEC2=3, EXEC3=4, HALTED=7.

## Operation
- State register states: FETCH_ADDR, FETCH_INSTR, EXEC1, EXEC2, EXEC3, HALTED.
- All control outputs are combinational decodes of state, `opcode` and flags. Any output not listed for a step is 0.
- FETCH_ADDR: `pc_oe`, `mar_load`. Next state FETCH_INSTR.
- FETCH_INSTR: `ram_oe`, `ir_load`, `pc_enable`. Next state EXEC1, unconditionally.
- Execute steps per opcode. "→F" means return to FETCH_ADDR after that step.
  - 0000 NOP: E1 none →F.
  - 0001 LDA: E1 `ir_oe`+`mar_load`; E2 `ram_oe`+`a_load` →F.
  - 0010 ADD: E1 `ir_oe`+`mar_load`; E2 `ram_oe`+`b_load`; E3 `alu_oe`+`a_load`+`flags_load` →F.
  - 0011 SUB: same as ADD, with `alu_sub`=1 in E3.
  - 0100 STA: E1 `ir_oe`+`mar_load`; E2 `a_oe`+`ram_we` →F.
  - 0101 LDI: E1 `ir_oe`+`a_load` →F.
  - 0110 JMP: E1 `ir_oe`+`pc_load` →F.
  - 0111 JC: E1 `ir_oe`+`pc_load` only if `flag_carry`=1, else none →F.
  - 1000 JZ: E1 `ir_oe`+`pc_load` only if `flag_zero`=1, else none →F.
  - 1110 OUT: E1 `a_oe`+`out_load` →F.
  - 1111 HLT: E1 `halt` → HALTED.
  - Opcodes 1001–1101 execute as NOP.
- HALTED: `halt`=1, all other outputs 0. The block stays in HALTED until `reset`.
- Invariants, checked in every cycle:
  - At most one of `pc_oe`, `ram_oe`, `ir_oe`, `a_oe`, `alu_oe` is high.
  - `pc_enable` and `pc_load` are never high together.
  - `ram_we` is never high together with `ram_oe`.

## Timing
- Reset:
  - While `reset`=1, all control outputs are forced to 0.
  - The state is set to FETCH_ADDR at the clock edge; `t_state` reads 0.
  - The first cycle after release is FETCH_ADDR.
  - Reset has priority in every state, including mid-execute and HALTED. The instruction in progress is abandoned with no further strobes.
- Instruction lengths, fetch included:
  - NOP, LDI, JMP, JC, JZ, OUT, undefined opcodes: 3 cycles.
  - LDA, STA: 4 cycles.
  - ADD, SUB: 5 cycles.
  - HLT: 3 cycles, then HALTED indefinitely.
- The PC increments at the end of FETCH_INSTR. A jump's `pc_load` occurs at the end of EXEC1 and overrides that increment; the next FETCH_ADDR presents the target address.
- JC/JZ sample the flags combinationally during EXEC1. Flags written by an ADD/SUB at the end of its EXEC3 are visible to an immediately following JC/JZ.
- The IR loads at the end of FETCH_INSTR. `opcode` is decoded only in EXEC1–EXEC3 and ignored in the fetch states.

## Test plan
- Reset and NOP:
  - Hold `reset` 2 cycles, then release with `opcode`=0000.
  - Required: all outputs 0 during reset; `t_state` sequence 0,1,2,0,1,2.
  - `pc_enable` high only in `t_state` 1.
- LDA vs STA:
  - `opcode`=0001 → E1 `ir_oe`&`mar_load`, E2 `ram_oe`&`a_load`, then `t_state`=0 (4-cycle loop).
  - `opcode`=0100 → E2 `a_oe`&`ram_we`.
- ADD/SUB:
  - `opcode`=0010 → 5-cycle loop; E3 `alu_oe`,`a_load`,`flags_load` high and `alu_sub`=0.
  - `opcode`=0011 → identical except `alu_sub`=1 in E3.
- Conditional jumps:
  - JC with `flag_carry`=1 → `pc_load`&`ir_oe` in E1.
  - JC with `flag_carry`=0 → no strobes in E1.
  - JZ: repeat both cases with `flag_zero`.
  - Undefined opcode 1010 → NOP behaviour.
- HLT and recovery:
  - `opcode`=1111 → `halt` rises in E1, `t_state`=7, and the block stays halted for 20 cycles with the other outputs at 0.
  - Assert `reset` → FETCH_ADDR resumes.
- Reset mid-ADD:
  - Assert `reset` during EXEC2 of ADD.
  - Required: no EXEC3 strobes, `flags_load` never asserted, next state FETCH_ADDR.
  - Bus-driver one-hot assertion holds throughout.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Control sequencer for the SAP-1.5 CPU: steps every instruction through
// fetch and execute micro-steps and decodes the datapath control strobes
// from the current step, the opcode and the flags.
module microcode_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       flag_carry,
  input  logic       flag_zero,
  output logic       pc_oe,
  output logic       pc_enable,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_load,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halt,
  output logic [2:0] t_state
);

  // Step encoding doubles as the debug value on t_state.
  typedef enum logic [2:0] {
    S_FETCH_ADDR  = 3'd0,
    S_FETCH_INSTR = 3'd1,
    S_EXEC1       = 3'd2,
    S_EXEC2       = 3'd3,
    S_EXEC3       = 3'd4,
    S_HALTED      = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t r_state;

  assign t_state = r_state;

  // Step sequencing; reset wins in every step, including HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH_ADDR;
    end else begin
      case (r_state)
        S_FETCH_ADDR:  r_state <= S_FETCH_INSTR;
        S_FETCH_INSTR: r_state <= S_EXEC1;
        S_EXEC1: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: r_state <= S_EXEC2;
            OP_HLT:                         r_state <= S_HALTED;
            default:                        r_state <= S_FETCH_ADDR;
          endcase
        end
        S_EXEC2: begin
          if (opcode == OP_ADD || opcode == OP_SUB) r_state <= S_EXEC3;
          else                                      r_state <= S_FETCH_ADDR;
        end
        S_EXEC3:  r_state <= S_FETCH_ADDR;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_FETCH_ADDR;
      endcase
    end
  end

  // Control decode; everything is held low while reset is asserted so an
  // abandoned instruction issues no further strobes.
  always_comb begin
    pc_oe      = 1'b0;
    pc_enable  = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_oe     = 1'b0;
    ram_we     = 1'b0;
    ir_load    = 1'b0;
    ir_oe      = 1'b0;
    a_load     = 1'b0;
    a_oe       = 1'b0;
    b_load     = 1'b0;
    alu_oe     = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halt       = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH_ADDR: begin
          pc_oe    = 1'b1;
          mar_load = 1'b1;
        end
        S_FETCH_INSTR: begin
          ram_oe    = 1'b1;
          ir_load   = 1'b1;
          pc_enable = 1'b1;
        end
        S_EXEC1: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_oe    = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_oe  = 1'b1;
              a_load = 1'b1;
            end
            OP_JMP: begin
              ir_oe   = 1'b1;
              pc_load = 1'b1;
            end
            OP_JC: begin
              ir_oe   = flag_carry;
              pc_load = flag_carry;
            end
            OP_JZ: begin
              ir_oe   = flag_zero;
              pc_load = flag_zero;
            end
            OP_OUT: begin
              a_oe     = 1'b1;
              out_load = 1'b1;
            end
            OP_HLT:  halt = 1'b1;
            default: ;
          endcase
        end
        S_EXEC2: begin
          case (opcode)
            OP_LDA: begin
              ram_oe = 1'b1;
              a_load = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_oe = 1'b1;
              b_load = 1'b1;
            end
            OP_STA: begin
              a_oe   = 1'b1;
              ram_we = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC3: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_oe     = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end
        end
        S_HALTED: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: a per-cycle expectation of the full control
// word and step is queued by the driver and popped by an independent monitor.
module tb_microcode_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       flag_carry = 1'b0;
  logic       flag_zero = 1'b0;

  logic pc_oe, pc_enable, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt;
  logic [2:0] t_state;

  microcode_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .pc_oe      (pc_oe),
    .pc_enable  (pc_enable),
    .pc_load    (pc_load),
    .mar_load   (mar_load),
    .ram_oe     (ram_oe),
    .ram_we     (ram_we),
    .ir_load    (ir_load),
    .ir_oe      (ir_oe),
    .a_load     (a_load),
    .a_oe       (a_oe),
    .b_load     (b_load),
    .alu_oe     (alu_oe),
    .alu_sub    (alu_sub),
    .flags_load (flags_load),
    .out_load   (out_load),
    .halt       (halt),
    .t_state    (t_state)
  );

  // Control word bit masks, one per strobe.
  localparam logic [15:0] C_PC_OE  = 16'h8000;
  localparam logic [15:0] C_PC_EN  = 16'h4000;
  localparam logic [15:0] C_PC_LD  = 16'h2000;
  localparam logic [15:0] C_MAR_LD = 16'h1000;
  localparam logic [15:0] C_RAM_OE = 16'h0800;
  localparam logic [15:0] C_RAM_WE = 16'h0400;
  localparam logic [15:0] C_IR_LD  = 16'h0200;
  localparam logic [15:0] C_IR_OE  = 16'h0100;
  localparam logic [15:0] C_A_LD   = 16'h0080;
  localparam logic [15:0] C_A_OE   = 16'h0040;
  localparam logic [15:0] C_B_LD   = 16'h0020;
  localparam logic [15:0] C_ALU_OE = 16'h0010;
  localparam logic [15:0] C_ALU_SB = 16'h0008;
  localparam logic [15:0] C_FL_LD  = 16'h0004;
  localparam logic [15:0] C_OUT_LD = 16'h0002;
  localparam logic [15:0] C_HALT   = 16'h0001;

  logic [15:0] w_cw;
  assign w_cw = {pc_oe, pc_enable, pc_load, mar_load, ram_oe, ram_we, ir_load,
                 ir_oe, a_load, a_oe, b_load, alu_oe, alu_sub, flags_load,
                 out_load, halt};

  // ---------------- scoreboard state ----------------
  logic [18:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Execute-step plan for one instruction straight from the opcode table:
  // returns the number of execute steps and the strobes of each one.
  function automatic int exec_plan(input logic [3:0] op, input logic c,
                                   input logic z, output logic [15:0] s0,
                                   output logic [15:0] s1,
                                   output logic [15:0] s2);
    s0 = 16'h0; s1 = 16'h0; s2 = 16'h0;
    case (op)
      4'b0001: begin s0 = C_IR_OE | C_MAR_LD; s1 = C_RAM_OE | C_A_LD; return 2; end
      4'b0010: begin
        s0 = C_IR_OE | C_MAR_LD; s1 = C_RAM_OE | C_B_LD;
        s2 = C_ALU_OE | C_A_LD | C_FL_LD; return 3;
      end
      4'b0011: begin
        s0 = C_IR_OE | C_MAR_LD; s1 = C_RAM_OE | C_B_LD;
        s2 = C_ALU_OE | C_A_LD | C_FL_LD | C_ALU_SB; return 3;
      end
      4'b0100: begin s0 = C_IR_OE | C_MAR_LD; s1 = C_A_OE | C_RAM_WE; return 2; end
      4'b0101: begin s0 = C_IR_OE | C_A_LD; return 1; end
      4'b0110: begin s0 = C_IR_OE | C_PC_LD; return 1; end
      4'b0111: begin s0 = c ? (C_IR_OE | C_PC_LD) : 16'h0; return 1; end
      4'b1000: begin s0 = z ? (C_IR_OE | C_PC_LD) : 16'h0; return 1; end
      4'b1110: begin s0 = C_A_OE | C_OUT_LD; return 1; end
      4'b1111: begin s0 = C_HALT; return 1; end
      default: return 1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic [3:0] op, input logic c, input logic z,
                             input logic [15:0] cw, input logic [2:0] t);
    @(posedge clk); #1;
    reset      = 1'b0;
    opcode     = op;
    flag_carry = c;
    flag_zero  = z;
    exp_q.push_back({cw, t});
  endtask

  // One cycle with reset held: strobes forced low, step still the old one.
  task automatic reset_cycle(input logic [2:0] t);
    @(posedge clk); #1;
    reset  = 1'b1;
    opcode = 4'($urandom_range(0, 15));
    exp_q.push_back({16'h0, t});
  endtask

  // Whole instruction; fetch cycles see a random opcode since it is ignored
  // there. With abort set, reset is raised in the second execute step.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                           input bit abort);
    logic [15:0] s[3];
    int n;
    n = exec_plan(op, c, z, s[0], s[1], s[2]);
    drive_cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                C_PC_OE | C_MAR_LD, 3'd0);
    drive_cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                C_RAM_OE | C_IR_LD | C_PC_EN, 3'd1);
    for (int i = 0; i < n; i++) begin
      if (abort && i == 1) begin
        reset_cycle(3'd3);
        reset_cycle(3'd0);
        return;
      end
      drive_cycle(op, c, z, s[i], 3'(2 + i));
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [18:0] exp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        tests++;
        if ({w_cw, t_state} !== exp) begin
          fails++;
          $display("FAIL cycle_vec @%0t: got cw=%h t_state=%0d, expected cw=%h t_state=%0d",
                   $time, w_cw, t_state, exp[18:3], exp[2:0]);
        end
      end
      tests++;
      if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1 ||
          (pc_enable && pc_load) || (ram_we && ram_oe)) begin
        fails++;
        $display("FAIL invariant @%0t: got cw=%h, expected single bus driver and no strobe conflicts",
                 $time, w_cw);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset for two cycles, then NOP twice: step sequence 0,1,2,0,1,2.
    reset_cycle(3'd0);
    reset_cycle(3'd0);
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(4'b0000, 1'b1, 1'b1, 1'b0);
    // Directed coverage of each opcode class and both flag outcomes.
    run_instr(4'b0001, 1'b0, 1'b0, 1'b0);
    run_instr(4'b0100, 1'b0, 1'b0, 1'b0);
    run_instr(4'b0010, 1'b1, 1'b0, 1'b0);
    run_instr(4'b0011, 1'b0, 1'b1, 1'b0);
    run_instr(4'b0111, 1'b1, 1'b0, 1'b0);
    run_instr(4'b0111, 1'b0, 1'b1, 1'b0);
    run_instr(4'b1000, 1'b0, 1'b1, 1'b0);
    run_instr(4'b1000, 1'b1, 1'b0, 1'b0);
    run_instr(4'b1010, 1'b1, 1'b1, 1'b0);
    run_instr(4'b0101, 1'b0, 1'b0, 1'b0);
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0);
    run_instr(4'b1110, 1'b0, 1'b0, 1'b0);
    // Randomized instruction stream (halt excluded so the stream continues).
    for (int k = 0; k < 150; k++)
      run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1'b0);
    // Reset during the second execute step of an ADD.
    run_instr(4'b0010, 1'b1, 1'b1, 1'b1);
    run_instr(4'b0001, 1'b0, 1'b0, 1'b0);
    // Halt, stay halted regardless of inputs, then recover through reset.
    run_instr(4'b1111, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      drive_cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  C_HALT, 3'd7);
    reset_cycle(3'd7);
    reset_cycle(3'd0);
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(4'b0011, 1'b1, 1'b1, 1'b0);
    // Let the monitor consume the last expectation, then report.
    @(negedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
